// File: rtl/fetch_pkg.sv
// ============================================================================
// Module   : fetch_pkg
// Brief    : Shared types, default widths and offset sign-extension helper.
// Revision : 1.0
// ============================================================================
`default_nettype none

package fetch_pkg;

    localparam int PC_W_DEF       = 16;
    localparam int LUT_AW_DEF     = 5;
    localparam int OFF_W_DEF      = 8;
    localparam int IMEM_DEPTH_DEF = 1024;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        HALT  = 2'd2,
        FAULT = 2'd3
    } fetch_state_t;

    function automatic logic [PC_W_DEF-1:0] sext_off(input logic [OFF_W_DEF-1:0] off);
        return {{(PC_W_DEF-OFF_W_DEF){off[OFF_W_DEF-1]}}, off};
    endfunction

endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
// ============================================================================
// Module   : sat_counter
// Brief    : Up-counter that sticks at all-ones; clear wins over enable.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic             i_clr,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en && (r_count != {WIDTH{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/prog_ctr_fetch.sv
// ============================================================================
// Module   : prog_ctr_fetch
// Brief    : Program counter / fetch sequencer driving the branch-target LUT.
//            Optional macro FETCH_BOUNDS_CHECK_EN adds the IMEM bounds fault.
// Revision : 1.0
// ============================================================================
`default_nettype none

module prog_ctr_fetch
    import fetch_pkg::*;
#(
    parameter int PC_W       = PC_W_DEF,
    parameter int LUT_AW     = LUT_AW_DEF,
    parameter int OFF_W      = OFF_W_DEF,
    parameter int IMEM_DEPTH = IMEM_DEPTH_DEF
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              Start,
    input  logic [LUT_AW-1:0] StartIdx,
    input  logic              Stall,
    input  logic              BrAbs,
    input  logic [LUT_AW-1:0] BrIdx,
    input  logic              BrRel,
    input  logic [OFF_W-1:0]  BrOffset,
    input  logic              Halt,
    output logic [LUT_AW-1:0] LutAddr,
    input  logic [PC_W-1:0]   Target,
    output logic [PC_W-1:0]   PC,
    output logic              Done,
    output logic              Fault,
    output logic [15:0]       CycleCnt
);

    fetch_state_t      r_state;
    fetch_state_t      w_state_next;
    logic [PC_W-1:0]   r_pc;
    logic [PC_W-1:0]   w_pc_next;
    logic [PC_W-1:0]   w_pc_cand;
    logic [PC_W-1:0]   w_off_ext;
    logic              r_done;
    logic              w_cnt_en;
    logic              w_cnt_clr;

    assign w_off_ext = PC_W'(sext_off(BrOffset));

    // Candidate PC for a non-stalled, non-halting RUN cycle
    always_comb begin
        if (BrAbs) begin
            w_pc_cand = Target;
        end else if (BrRel) begin
            w_pc_cand = r_pc + w_off_ext;
        end else begin
            w_pc_cand = r_pc + 1'b1;
        end
    end

`ifdef FETCH_BOUNDS_CHECK_EN
    localparam logic [PC_W:0] c_imem_limit = (PC_W+1)'(IMEM_DEPTH);
    logic w_oob;
    assign w_oob = ({1'b0, w_pc_cand} >= c_imem_limit);
`endif

    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        LutAddr      = StartIdx;
        w_cnt_en     = 1'b0;
        w_cnt_clr    = 1'b0;
        case (r_state)
            RUN: begin
                LutAddr = BrIdx;
                if (!Stall) begin
                    w_cnt_en = 1'b1;
                    if (Halt) begin
                        w_state_next = HALT;
                    end else begin
`ifdef FETCH_BOUNDS_CHECK_EN
                        if (w_oob) begin
                            w_state_next = FAULT;
                        end else begin
                            w_pc_next = w_pc_cand;
                        end
`else
                        w_pc_next = w_pc_cand;
`endif
                    end
                end
            end
            // IDLE, HALT and FAULT all restart the same way on Start
            default: begin
                if (Start) begin
                    w_pc_next    = Target;
                    w_cnt_clr    = 1'b1;
                    w_state_next = RUN;
                end
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= IDLE;
            r_pc    <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            r_done  <= (w_state_next == HALT);
        end
    end

`ifdef FETCH_BOUNDS_CHECK_EN
    logic r_fault;
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_fault <= 1'b0;
        end else begin
            r_fault <= (w_state_next == FAULT);
        end
    end
    assign Fault = r_fault;
`else
    assign Fault = 1'b0;
`endif

    sat_counter #(
        .WIDTH (16)
    ) u_cycle_cnt (
        .i_clk   (Clk),
        .i_rst_n (Reset_n),
        .i_en    (w_cnt_en),
        .i_clr   (w_cnt_clr),
        .o_count (CycleCnt)
    );

    assign PC   = r_pc;
    assign Done = r_done;

endmodule

`default_nettype wire
